// File: rtl/spatz_spm_responder.sv
// spatz_spm_responder
//   Target-side endpoint of the SPM request/response channel. Accepts
//   TCDM-style requests, drives one single-port SRAM bank with a fixed read
//   latency and returns exactly one in-order response per request through a
//   fall-through response FIFO. A credit counter caps outstanding requests
//   at FifoDepth, so a response always has a FIFO slot when it leaves the
//   tag pipeline, even while the consumer holds p_ready_i low.
//
//   Ports
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     q_*_i / q_ready_o      request channel (addr, write, data, strb, user)
//     p_*_o / p_ready_i      response channel (data, user, error)
//     mem_*_o / mem_rdata_i  SRAM bank port; rdata valid MemLatency cycles
//                            after mem_req_o
//
//   Handshake: a beat transfers on a cycle where valid & ready are both 1.
//   Valid never depends on ready and, once raised, stays high with a stable
//   payload until it transfers. q_ready_o depends on registered state only.
module spatz_spm_responder #(
  parameter int unsigned AddrWidth    = 16,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned UserWidth    = 1,
  parameter int unsigned MemSizeBytes = 65536,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned FifoDepth    = 2,
  localparam int unsigned StrbWidth    = DataWidth / 8,
  localparam int unsigned WordOff      = $clog2(StrbWidth),
  localparam int unsigned MemAddrWidth = AddrWidth - WordOff
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    q_valid_i,
  output logic                    q_ready_o,
  input  logic [AddrWidth-1:0]    q_addr_i,
  input  logic                    q_write_i,
  input  logic [DataWidth-1:0]    q_data_i,
  input  logic [StrbWidth-1:0]    q_strb_i,
  input  logic [UserWidth-1:0]    q_user_i,
  output logic                    p_valid_o,
  input  logic                    p_ready_i,
  output logic [DataWidth-1:0]    p_data_o,
  output logic [UserWidth-1:0]    p_user_o,
  output logic                    p_error_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [StrbWidth-1:0]    mem_be_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic                 error;
    logic [UserWidth-1:0] user;
  } tag_t;

  typedef struct packed {
    logic                 error;
    logic [UserWidth-1:0] user;
    logic [DataWidth-1:0] data;
  } rsp_t;

  logic [CntW-1:0] cnt_q, cnt_d;    // accepted and not yet popped
  logic [CntW-1:0] fcnt_q, fcnt_d;  // entries stored in the FIFO
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  tag_t            tag_q [MemLatency];
  rsp_t            fifo_q [FifoDepth];

  logic accept, pop, in_range, push, empty, wr_en, rd_en;
  tag_t tag_in, tag_out;
  rsp_t push_rsp, head_rsp;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request side
  assign q_ready_o = (cnt_q < CntW'(FifoDepth));
  assign accept    = q_valid_i & q_ready_o;
  // Widened compare so MemSizeBytes == 2**AddrWidth is handled.
  assign in_range  = (64'(q_addr_i) < 64'(MemSizeBytes));

  // Out-of-range requests are still accepted but never touch the SRAM.
  assign mem_req_o   = accept & in_range;
  assign mem_we_o    = mem_req_o & q_write_i;
  assign mem_addr_o  = mem_req_o ? q_addr_i[AddrWidth-1:WordOff] : '0;
  assign mem_be_o    = mem_req_o ? q_strb_i : '0;
  assign mem_wdata_o = mem_req_o ? q_data_i : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.write = q_write_i;
    tag_in.error = ~in_range;
    tag_in.user  = q_user_i;
  end

  // Tag pipeline exit lines up with the SRAM read data.
  assign tag_out = tag_q[MemLatency-1];
  assign push    = tag_out.valid;

  always_comb begin
    push_rsp       = '0;
    push_rsp.error = tag_out.error;
    push_rsp.user  = tag_out.user;
    push_rsp.data  = (tag_out.write || tag_out.error) ? '0 : mem_rdata_i;
  end

  // Fall-through FIFO: when empty, the entry being pushed is shown directly.
  assign empty    = (fcnt_q == '0);
  assign head_rsp = empty ? push_rsp : fifo_q[rptr_q];
  assign p_valid_o = ~empty | push;
  assign p_data_o  = p_valid_o ? head_rsp.data  : '0;
  assign p_user_o  = p_valid_o ? head_rsp.user  : '0;
  assign p_error_o = p_valid_o ? head_rsp.error : 1'b0;
  assign pop       = p_valid_o & p_ready_i;

  // A push consumed in the same cycle by an empty FIFO bypasses storage.
  assign wr_en = push & ~(empty & pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    fcnt_d = fcnt_q + CntW'(wr_en) - CntW'(rd_en);
    wptr_d = wr_en ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = rd_en ? ptr_inc(rptr_q) : rptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(MemLatency); i++) tag_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(MemLatency); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Storage is qualified by fcnt_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) fifo_q[wptr_q] <= push_rsp;
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (MemLatency >= 1 && FifoDepth >= 1 && (DataWidth % 8) == 0);
      assert (!(push && fcnt_q == CntW'(FifoDepth)));
      assert (cnt_q <= CntW'(FifoDepth));
    end
  end

endmodule

// File: tb/tb_spatz_spm_responder.sv
module tb_spatz_spm_responder;

  localparam int UW = 4;
  localparam int EW = 52;  // {due_cycle[15:0], user[3:0], data[31:0]}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A: latency 1, depth 2, 17-bit addresses ----------
  logic        a_q_valid, a_q_ready, a_q_write, a_p_valid, a_p_ready, a_p_error;
  logic [16:0] a_q_addr;
  logic [31:0] a_q_data, a_p_data, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_q_strb, a_q_user, a_p_user, a_mem_be;
  logic        a_mem_req, a_mem_we;
  logic [14:0] a_mem_addr;

  spatz_spm_responder #(
    .AddrWidth(17), .DataWidth(32), .UserWidth(UW), .MemSizeBytes(32'h10000),
    .MemLatency(1), .FifoDepth(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .q_valid_i(a_q_valid), .q_ready_o(a_q_ready), .q_addr_i(a_q_addr),
    .q_write_i(a_q_write), .q_data_i(a_q_data), .q_strb_i(a_q_strb),
    .q_user_i(a_q_user), .p_valid_o(a_p_valid), .p_ready_i(a_p_ready),
    .p_data_o(a_p_data), .p_user_o(a_p_user), .p_error_o(a_p_error),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_be_o(a_mem_be), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  // ---------------- DUT B: latency 3, depth 4, 16-bit addresses ----------
  logic        b_q_valid, b_q_ready, b_q_write, b_p_valid, b_p_ready, b_p_error;
  logic [15:0] b_q_addr;
  logic [31:0] b_q_data, b_p_data, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_q_strb, b_q_user, b_p_user, b_mem_be;
  logic        b_mem_req, b_mem_we;
  logic [13:0] b_mem_addr;

  spatz_spm_responder #(
    .AddrWidth(16), .DataWidth(32), .UserWidth(UW), .MemSizeBytes(65536),
    .MemLatency(3), .FifoDepth(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .q_valid_i(b_q_valid), .q_ready_o(b_q_ready), .q_addr_i(b_q_addr),
    .q_write_i(b_q_write), .q_data_i(b_q_data), .q_strb_i(b_q_strb),
    .q_user_i(b_q_user), .p_valid_o(b_p_valid), .p_ready_i(b_p_ready),
    .p_data_o(b_p_data), .p_user_o(b_p_user), .p_error_o(b_p_error),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // ---------------- SRAM bank models ----------------
  logic [31:0] mem_a [0:32767];
  logic [31:0] mem_b [0:16383];
  logic [31:0] b_r0, b_r1;

  always @(posedge clk) begin
    if (a_mem_req) begin
      if (a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) mem_a[a_mem_addr][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end else begin
        a_mem_rdata <= mem_a[a_mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (b_mem_req) begin
      if (b_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b_mem_be[k]) mem_b[b_mem_addr][8*k +: 8] <= b_mem_wdata[8*k +: 8];
      end else begin
        b_r0 <= mem_b[b_mem_addr];
      end
    end
    b_r1        <= b_r0;
    b_mem_rdata <= b_r1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [16:0] addr, input logic wr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic [3:0] user);
    a_q_valid = v; a_q_addr = addr; a_q_write = wr;
    a_q_data = data; a_q_strb = strb; a_q_user = user;
  endtask

  // ---------------- scoreboard for DUT B ----------------
  logic [EW-1:0] exp_q[$];
  logic [31:0]   ref_b [0:63];

  initial begin
    logic [EW-1:0] e;
    logic [31:0]   exp_data;
    int            w;
    int            cyc;

    for (int i = 0; i < 32768; i++) mem_a[i] = '0;
    for (int i = 0; i < 16384; i++) mem_b[i] = '0;
    for (int i = 0; i < 64; i++) ref_b[i] = '0;
    a_mem_rdata = '0; b_r0 = '0; b_r1 = '0; b_mem_rdata = '0;

    // clock/reset
    rst_n = 1'b0;
    drive_a(1'b0, '0, 1'b0, '0, '0, '0);
    a_p_ready = 1'b1;
    b_q_valid = 1'b0; b_q_addr = '0; b_q_write = 1'b0; b_q_data = '0;
    b_q_strb = '0; b_q_user = '0; b_p_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    sample();
    check_eq("rst_q_ready", a_q_ready, 1);
    check_eq("rst_p_valid", a_p_valid, 0);
    check_eq("rst_mem_req", a_mem_req, 0);
    check_eq("rst_mem_we", a_mem_we, 0);
    check_eq("rst_p_data", a_p_data, 0);
    check_eq("rst_b_p_valid", b_p_valid, 0);

    // 1: write then read of the same word
    step();
    drive_a(1'b1, 17'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 4'h5);
    sample();
    check_eq("t1_wr_mem_req", a_mem_req, 1);
    check_eq("t1_wr_mem_we", a_mem_we, 1);
    check_eq("t1_wr_mem_addr", a_mem_addr, 15'h4);
    check_eq("t1_wr_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    check_eq("t1_wr_mem_be", a_mem_be, 4'hF);
    check_eq("t1_wr_p_valid", a_p_valid, 0);
    step();
    drive_a(1'b1, 17'h0010, 1'b0, 32'h0, 4'hF, 4'h6);
    sample();
    check_eq("t1_wrsp_valid", a_p_valid, 1);
    check_eq("t1_wrsp_data", a_p_data, 0);
    check_eq("t1_wrsp_user", a_p_user, 4'h5);
    check_eq("t1_wrsp_err", a_p_error, 0);
    check_eq("t1_rd_mem_we", a_mem_we, 0);
    check_eq("t1_q_ready", a_q_ready, 1);
    step();
    drive_a(1'b0, '0, 1'b0, '0, '0, '0);
    sample();
    check_eq("t1_rrsp_valid", a_p_valid, 1);
    check_eq("t1_rrsp_data", a_p_data, 32'hDEADBEEF);
    check_eq("t1_rrsp_user", a_p_user, 4'h6);
    check_eq("t1_rrsp_err", a_p_error, 0);
    step();
    sample();
    check_eq("t1_idle_valid", a_p_valid, 0);

    // 2: backpressure with three back-to-back reads
    step();
    a_p_ready = 1'b0;
    drive_a(1'b1, 17'h0010, 1'b0, '0, 4'hF, 4'h1);
    sample();
    check_eq("t2_c0_q_ready", a_q_ready, 1);
    check_eq("t2_c0_mem_req", a_mem_req, 1);
    step();
    a_q_user = 4'h2;
    sample();
    check_eq("t2_c1_q_ready", a_q_ready, 1);
    check_eq("t2_c1_p_user", a_p_user, 4'h1);
    step();
    a_q_user = 4'h3;
    sample();
    check_eq("t2_c2_q_ready", a_q_ready, 0);
    check_eq("t2_c2_mem_req", a_mem_req, 0);
    check_eq("t2_c2_p_valid", a_p_valid, 1);
    step();
    sample();
    check_eq("t2_c3_q_ready", a_q_ready, 0);
    check_eq("t2_c3_p_user", a_p_user, 4'h1);
    check_eq("t2_c3_p_data", a_p_data, 32'hDEADBEEF);
    step();
    a_p_ready = 1'b1;
    sample();
    check_eq("t2_c4_q_ready", a_q_ready, 0);
    check_eq("t2_c4_p_user", a_p_user, 4'h1);
    step();
    sample();
    // 3: accept and pop together at cnt = depth-1
    check_eq("t3_c5_q_ready", a_q_ready, 1);
    check_eq("t3_c5_mem_req", a_mem_req, 1);
    check_eq("t3_c5_p_user", a_p_user, 4'h2);
    step();
    drive_a(1'b0, '0, 1'b0, '0, '0, '0);
    sample();
    check_eq("t3_c6_q_ready", a_q_ready, 1);
    check_eq("t3_c6_p_valid", a_p_valid, 1);
    check_eq("t3_c6_p_user", a_p_user, 4'h3);
    check_eq("t3_c6_p_data", a_p_data, 32'hDEADBEEF);
    step();
    sample();
    check_eq("t3_c7_p_valid", a_p_valid, 0);

    // 4: out-of-range read
    step();
    drive_a(1'b1, 17'h10000, 1'b0, '0, 4'hF, 4'h7);
    sample();
    check_eq("t4_mem_req", a_mem_req, 0);
    check_eq("t4_q_ready", a_q_ready, 1);
    step();
    drive_a(1'b0, '0, 1'b0, '0, '0, '0);
    sample();
    check_eq("t4_p_valid", a_p_valid, 1);
    check_eq("t4_p_error", a_p_error, 1);
    check_eq("t4_p_data", a_p_data, 0);
    check_eq("t4_p_user", a_p_user, 4'h7);
    step();
    sample();
    check_eq("t4_done", a_p_valid, 0);

    // 5: latency 3 / depth 4 random traffic against a reference memory
    step();
    cyc = 0;
    for (int n = 0; n < 106; n++) begin
      if (n < 100) begin
        w = $urandom_range(0, 63);
        b_q_valid = 1'b1;
        b_q_write = 1'($urandom_range(0, 1));
        b_q_addr  = 16'((w << 2) | $urandom_range(0, 3));
        b_q_data  = $urandom;
        b_q_strb  = 4'($urandom_range(0, 15));
        b_q_user  = 4'($urandom_range(0, 15));
      end else begin
        b_q_valid = 1'b0;
      end
      sample();
      if (b_p_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("t5_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("t5_rsp_data", b_p_data, e[31:0]);
          check_eq("t5_rsp_user", b_p_user, e[35:32]);
          check_eq("t5_rsp_cycle", 16'(cyc), e[51:36]);
          check_eq("t5_rsp_err", b_p_error, 0);
        end
      end else if (exp_q.size() > 0 && exp_q[0][51:36] == 16'(cyc)) begin
        check_eq("t5_missing_rsp", 0, 1);
      end
      if (n < 100) begin
        check_eq("t5_q_ready", b_q_ready, 1);
        if (b_q_ready) begin
          w = int'(b_q_addr[7:2]);
          exp_data = '0;
          if (b_q_write) begin
            for (int k = 0; k < 4; k++)
              if (b_q_strb[k]) ref_b[w][8*k +: 8] = b_q_data[8*k +: 8];
          end else begin
            exp_data = ref_b[w];
          end
          exp_q.push_back({16'(cyc + 3), b_q_user, exp_data});
        end
      end
      step();
      cyc++;
    end
    check_eq("t5_drained", 64'(exp_q.size()), 0);

    // 6: reset with two requests in flight
    a_p_ready = 1'b0;
    drive_a(1'b1, 17'h0010, 1'b0, '0, 4'hF, 4'h8);
    step();
    a_q_user = 4'h9;
    step();
    drive_a(1'b0, '0, 1'b0, '0, '0, '0);
    sample();
    check_eq("t6_pre_p_valid", a_p_valid, 1);
    check_eq("t6_pre_q_ready", a_q_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_p_valid", a_p_valid, 0);
    check_eq("t6_rst_q_ready", a_q_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    a_p_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("t6_no_stale", a_p_valid, 0);
      step();
    end
    drive_a(1'b1, 17'h0010, 1'b0, '0, 4'hF, 4'hA);
    step();
    drive_a(1'b0, '0, 1'b0, '0, '0, '0);
    sample();
    check_eq("t6_fresh_valid", a_p_valid, 1);
    check_eq("t6_fresh_user", a_p_user, 4'hA);
    check_eq("t6_fresh_data", a_p_data, 32'hDEADBEEF);
    step();
    sample();
    check_eq("t6_fresh_done", a_p_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
